// File: rtl/bk_port_mouse.sv
// BK0010/BK0011M port 177714 input stage: merges joystick and PS/2 mouse into the CPU read word.
// Mouse packets become BK mouse-adapter direction/button bits via per-axis thresholded accumulators.
module bk_port_mouse #(
    parameter int          THRESH     = 3,
    parameter int unsigned HOLD_TICKS = 0,
    parameter int unsigned ACC_W      = 10
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        port_sel,
    input  logic        bus_stb,
    input  logic        bus_we,
    input  logic [1:0]  bus_wtbt,
    input  logic [15:0] bus_din,
    input  logic [24:0] ps2_mouse,
    input  logic [15:0] joystick,
    output logic [15:0] bus_dout,
    output logic        mouse_en
);

    localparam int unsigned CNT_W = (HOLD_TICKS > 2) ? $clog2(HOLD_TICKS) : 1;

    localparam logic signed [ACC_W:0]   SUM_MAX = (ACC_W + 1)'(2 ** (ACC_W - 1) - 1);
    localparam logic signed [ACC_W:0]   SUM_MIN = -SUM_MAX;
    localparam logic signed [ACC_W-1:0] THR_POS = ACC_W'(THRESH);
    localparam logic signed [ACC_W-1:0] THR_NEG = ACC_W'(-THRESH);

    // state bits: [0] up, [1] right, [2] down, [3] left, [4] zero, [5] L button, [6] R button
    logic [6:0]              state_q, state_d;
    logic                    mouse_en_q, mouse_en_d;
    logic                    src_q, src_d;
    logic signed [ACC_W-1:0] acc_x_q, acc_x_d;
    logic signed [ACC_W-1:0] acc_y_q, acc_y_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    tog_q;
    logic                    wr_q, wr_prev_q, wr_bit_q;

    logic                    wr_req;
    logic                    wr_rise;
    logic                    pkt;
    logic signed [ACC_W-1:0] dx_ext, dy_ext;
    logic signed [ACC_W-1:0] sum_x, sum_y;
    logic                    set_any;
    logic                    unused_bits;

    function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                        input logic signed [ACC_W-1:0] b);
        logic signed [ACC_W:0] s;
        s = (ACC_W + 1)'(a) + (ACC_W + 1)'(b);
        if (s > SUM_MAX) begin
            s = SUM_MAX;
        end else if (s < SUM_MIN) begin
            s = SUM_MIN;
        end
        return s[ACC_W-1:0];
    endfunction

    assign wr_req  = bus_stb & port_sel & bus_we & bus_wtbt[0];
    assign wr_rise = wr_q & ~wr_prev_q;
    assign pkt     = ps2_mouse[24] ^ tog_q;

    // hps_io delivers each delta as a 9-bit two's complement value split across the packet
    assign dx_ext = ACC_W'($signed({ps2_mouse[4], ps2_mouse[15:8]}));
    assign dy_ext = ACC_W'($signed({ps2_mouse[5], ps2_mouse[23:16]}));

    assign unused_bits = ^{bus_din[15:4], bus_din[2:0], bus_wtbt[1], ps2_mouse[7:6],
                           ps2_mouse[3:2]};

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= '0;
            mouse_en_q <= 1'b0;
            src_q      <= 1'b0;
            acc_x_q    <= '0;
            acc_y_q    <= '0;
            cnt_q      <= '0;
            tog_q      <= 1'b0;
            wr_q       <= 1'b0;
            wr_prev_q  <= 1'b0;
            wr_bit_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            mouse_en_q <= mouse_en_d;
            src_q      <= src_d;
            acc_x_q    <= acc_x_d;
            acc_y_q    <= acc_y_d;
            cnt_q      <= cnt_d;
            tog_q      <= ps2_mouse[24];
            wr_q       <= wr_req;
            wr_prev_q  <= wr_q;
            if (wr_req) begin
                wr_bit_q <= bus_din[3];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        mouse_en_d = mouse_en_q;
        src_d      = src_q;
        acc_x_d    = acc_x_q;
        acc_y_d    = acc_y_q;
        cnt_d      = cnt_q;
        sum_x      = '0;
        sum_y      = '0;
        set_any    = 1'b0;

        if (joystick != 16'd0) begin
            src_d = 1'b0;
        end

        if (pkt) begin
            src_d      = 1'b1;
            state_d[6] = ps2_mouse[1];
            state_d[5] = ps2_mouse[0];
            if (mouse_en_q) begin
                // An axis with a pending step ignores motion until the step is consumed
                if (state_q[0] | state_q[2]) begin
                    acc_y_d = '0;
                end else begin
                    sum_y = sat_add(acc_y_q, dy_ext);
                    if (sum_y > THR_POS) begin
                        state_d[0] = 1'b1;
                        acc_y_d    = '0;
                        set_any    = 1'b1;
                    end else if (sum_y < THR_NEG) begin
                        state_d[2] = 1'b1;
                        acc_y_d    = '0;
                        set_any    = 1'b1;
                    end else begin
                        acc_y_d = sum_y;
                    end
                end

                if (state_q[1] | state_q[3]) begin
                    acc_x_d = '0;
                end else begin
                    sum_x = sat_add(acc_x_q, dx_ext);
                    if (sum_x > THR_POS) begin
                        state_d[1] = 1'b1;
                        acc_x_d    = '0;
                        set_any    = 1'b1;
                    end else if (sum_x < THR_NEG) begin
                        state_d[3] = 1'b1;
                        acc_x_d    = '0;
                        set_any    = 1'b1;
                    end else begin
                        acc_x_d = sum_x;
                    end
                end
            end
        end

        if (HOLD_TICKS > 0) begin
            if (set_any) begin
                cnt_d = '0;
            end else if ((state_q[3:0] != 4'd0) && ce) begin
                if (cnt_q == CNT_W'(HOLD_TICKS - 1)) begin
                    state_d[3:0] = 4'd0;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        // CPU write acts last so a clear always beats a same-cycle set or release
        if (wr_rise) begin
            mouse_en_d = wr_bit_q;
            if (!wr_bit_q) begin
                state_d[3:0] = 4'd0;
                acc_x_d      = '0;
                acc_y_d      = '0;
                cnt_d        = '0;
            end
        end

        state_d[4] = 1'b0;
    end

    always_comb begin
        bus_dout = 16'd0;
        if (port_sel) begin
            bus_dout = src_q ? {9'd0, state_q} : joystick;
        end
    end

    assign mouse_en = mouse_en_q;

endmodule

// File: tb/tb_bk_port_mouse.sv
// Self-checking bench for bk_port_mouse: directed vector table, randomized run against a
// transaction-level mouse model, and hand sequences for auto-release and async reset.
module tb_bk_port_mouse;

    localparam int OP_IDLE = 0;
    localparam int OP_PKT  = 1;
    localparam int OP_WR   = 2;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce = 1'b0;
    logic        port_sel = 1'b0;
    logic        bus_stb = 1'b0;
    logic        bus_we = 1'b0;
    logic [1:0]  bus_wtbt = 2'b00;
    logic [15:0] bus_din = 16'd0;
    logic [24:0] ps2_mouse = 25'd0;
    logic [15:0] joystick = 16'd0;
    logic [15:0] dout0, dout4;
    logic        men0, men4;

    int   n_cmp = 0;
    int   n_fail = 0;
    logic tog = 1'b0;

    // reference model: named direction flags, integer accumulators
    int m_ax, m_ay;
    bit m_up, m_dn, m_lf, m_rt, m_lb, m_rb, m_en, m_src;

    typedef struct {
        int          op;
        logic [15:0] din;
        logic [1:0]  wtbt;
        int          dx;
        int          dy;
        logic [1:0]  btn;
        logic [15:0] joy;
        logic        psel;
        logic [15:0] exp_dout;
        logic        exp_men;
    } vec_t;

    vec_t vt[$];

    bk_port_mouse #(.THRESH(3), .HOLD_TICKS(0), .ACC_W(10)) dut0 (
        .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce), .port_sel(port_sel), .bus_stb(bus_stb),
        .bus_we(bus_we), .bus_wtbt(bus_wtbt), .bus_din(bus_din), .ps2_mouse(ps2_mouse),
        .joystick(joystick), .bus_dout(dout0), .mouse_en(men0)
    );

    bk_port_mouse #(.THRESH(3), .HOLD_TICKS(4), .ACC_W(10)) dut4 (
        .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce), .port_sel(port_sel), .bus_stb(bus_stb),
        .bus_we(bus_we), .bus_wtbt(bus_wtbt), .bus_din(bus_din), .ps2_mouse(ps2_mouse),
        .joystick(joystick), .bus_dout(dout4), .mouse_en(men4)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clk_step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic drive(input int op, input logic [15:0] din, input logic [1:0] wtbt,
                         input logic we, input int dx, input int dy, input logic [1:0] btn,
                         input logic [15:0] joy, input logic psel);
        logic [31:0] x, y;
        x = dx;
        y = dy;
        joystick = joy;
        port_sel = psel;
        if (op == OP_PKT) begin
            tog = ~tog;
            ps2_mouse = {tog, y[7:0], x[7:0], 2'b00, y[8], x[8], 2'b00, btn};
            clk_step();
        end else if (op == OP_WR) begin
            bus_stb  = 1'b1;
            bus_we   = we;
            bus_wtbt = wtbt;
            bus_din  = din;
            clk_step();
            bus_stb  = 1'b0;
            bus_we   = 1'b0;
            bus_wtbt = 2'b00;
            clk_step();
        end else begin
            clk_step();
        end
    endtask

    task automatic model_reset();
        m_ax = 0; m_ay = 0;
        m_up = 0; m_dn = 0; m_lf = 0; m_rt = 0;
        m_lb = 0; m_rb = 0; m_en = 0; m_src = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        ce = 1'b0; bus_stb = 1'b0; bus_we = 1'b0; bus_wtbt = 2'b00;
        ps2_mouse = 25'd0; tog = 1'b0; joystick = 16'd0; port_sel = 1'b0;
        model_reset();
        repeat (2) clk_step();
        reset_n = 1'b1;
        clk_step();
    endtask

    task automatic ce_tick();
        repeat (23) clk_step();
        ce = 1'b1;
        clk_step();
        ce = 1'b0;
    endtask

    function automatic int clamp(input int v);
        if (v > 511) return 511;
        if (v < -511) return -511;
        return v;
    endfunction

    task automatic model_axis(input int d, inout int acc, inout bit pos, inout bit neg);
        if (pos || neg) begin
            acc = 0;
        end else begin
            acc = clamp(acc + d);
            if (acc > 3) begin
                pos = 1; acc = 0;
            end else if (acc < -3) begin
                neg = 1; acc = 0;
            end
        end
    endtask

    task automatic model_packet(input int dx, input int dy, input logic [1:0] btn);
        m_rb = btn[1];
        m_lb = btn[0];
        m_src = 1;
        if (m_en) begin
            model_axis(dy, m_ay, m_up, m_dn);
            model_axis(dx, m_ax, m_rt, m_lf);
        end
    endtask

    task automatic model_write(input logic [15:0] din);
        m_en = din[3];
        if (!din[3]) begin
            m_up = 0; m_dn = 0; m_lf = 0; m_rt = 0;
            m_ax = 0; m_ay = 0;
        end
    endtask

    function automatic logic [15:0] model_word(input logic psel, input logic [15:0] joy);
        if (!psel) return 16'd0;
        if (!m_src) return joy;
        return {9'd0, m_rb, m_lb, 1'b0, m_lf, m_dn, m_rt, m_up};
    endfunction

    function automatic vec_t mk(input int op, input logic [15:0] din, input logic [1:0] wtbt,
                                input int dx, input int dy, input logic [1:0] btn,
                                input logic [15:0] joy, input logic psel,
                                input logic [15:0] ed, input logic em);
        vec_t v;
        v.op = op; v.din = din; v.wtbt = wtbt; v.dx = dx; v.dy = dy; v.btn = btn;
        v.joy = joy; v.psel = psel; v.exp_dout = ed; v.exp_men = em;
        return v;
    endfunction

    initial begin
        //                op       din      wtbt   dx    dy   btn    joy       psel  dout    men
        vt.push_back(mk(OP_IDLE, 16'h0000, 2'b00,   0,    0, 2'b00, 16'h0005, 1'b1, 16'h0005, 1'b0));
        vt.push_back(mk(OP_IDLE, 16'h0000, 2'b00,   0,    0, 2'b00, 16'h0000, 1'b0, 16'h0000, 1'b0));
        vt.push_back(mk(OP_WR,   16'h0008, 2'b01,   0,    0, 2'b00, 16'h0000, 1'b1, 16'h0000, 1'b1));
        vt.push_back(mk(OP_PKT,  16'h0000, 2'b00,   0,    4, 2'b00, 16'h0000, 1'b1, 16'h0001, 1'b1));
        vt.push_back(mk(OP_PKT,  16'h0000, 2'b00,   0,    9, 2'b00, 16'h0000, 1'b1, 16'h0001, 1'b1));
        vt.push_back(mk(OP_WR,   16'h0000, 2'b01,   0,    0, 2'b00, 16'h0000, 1'b1, 16'h0000, 1'b0));
        vt.push_back(mk(OP_WR,   16'h0008, 2'b01,   0,    0, 2'b00, 16'h0000, 1'b1, 16'h0000, 1'b1));
        vt.push_back(mk(OP_PKT,  16'h0000, 2'b00,  -2,    0, 2'b00, 16'h0000, 1'b1, 16'h0000, 1'b1));
        vt.push_back(mk(OP_PKT,  16'h0000, 2'b00,  -2,    0, 2'b00, 16'h0000, 1'b1, 16'h0008, 1'b1));
        vt.push_back(mk(OP_PKT,  16'h0000, 2'b00,  -2,    0, 2'b00, 16'h0000, 1'b1, 16'h0008, 1'b1));
        vt.push_back(mk(OP_PKT,  16'h0000, 2'b00,   0,    0, 2'b01, 16'h0000, 1'b1, 16'h0028, 1'b1));
        vt.push_back(mk(OP_PKT,  16'h0000, 2'b00,   0,   -3, 2'b01, 16'h0000, 1'b1, 16'h0028, 1'b1));
        vt.push_back(mk(OP_PKT,  16'h0000, 2'b00,   0,   -1, 2'b01, 16'h0000, 1'b1, 16'h002C, 1'b1));
        vt.push_back(mk(OP_WR,   16'h0000, 2'b01,   0,    0, 2'b00, 16'h0000, 1'b1, 16'h0020, 1'b0));
        vt.push_back(mk(OP_PKT,  16'h0000, 2'b00,   0,  100, 2'b10, 16'h0000, 1'b1, 16'h0040, 1'b0));
        vt.push_back(mk(OP_PKT,  16'h0000, 2'b00,  50,    0, 2'b11, 16'h0000, 1'b1, 16'h0060, 1'b0));
        vt.push_back(mk(OP_IDLE, 16'h0000, 2'b00,   0,    0, 2'b00, 16'h0300, 1'b1, 16'h0300, 1'b0));
        vt.push_back(mk(OP_PKT,  16'h0000, 2'b00,   0,    0, 2'b01, 16'h0300, 1'b1, 16'h0020, 1'b0));
        vt.push_back(mk(OP_IDLE, 16'h0000, 2'b00,   0,    0, 2'b00, 16'h0300, 1'b1, 16'h0300, 1'b0));
        vt.push_back(mk(OP_IDLE, 16'h0000, 2'b00,   0,    0, 2'b00, 16'h0000, 1'b0, 16'h0000, 1'b0));
        vt.push_back(mk(OP_WR,   16'h0008, 2'b10,   0,    0, 2'b00, 16'h0000, 1'b1, 16'h0000, 1'b0));
        vt.push_back(mk(OP_WR,   16'h0008, 2'b11,   0,    0, 2'b00, 16'h0000, 1'b1, 16'h0000, 1'b1));
        vt.push_back(mk(OP_PKT,  16'h0000, 2'b00, 255,    0, 2'b00, 16'h0000, 1'b1, 16'h0002, 1'b1));
        vt.push_back(mk(OP_PKT,  16'h0000, 2'b00,   0, -256, 2'b00, 16'h0000, 1'b1, 16'h0006, 1'b1));
        vt.push_back(mk(OP_WR,   16'h0000, 2'b01,   0,    0, 2'b00, 16'h0000, 1'b1, 16'h0000, 1'b0));
        vt.push_back(mk(OP_WR,   16'h0008, 2'b01,   0,    0, 2'b00, 16'h0000, 1'b1, 16'h0000, 1'b1));
        vt.push_back(mk(OP_PKT,  16'h0000, 2'b00,   3,    0, 2'b00, 16'h0000, 1'b1, 16'h0000, 1'b1));
        vt.push_back(mk(OP_PKT,  16'h0000, 2'b00,   1,    0, 2'b00, 16'h0000, 1'b1, 16'h0002, 1'b1));

        // reset state, observed while reset is still asserted
        joystick = 16'h0005;
        port_sel = 1'b1;
        #3;
        check("reset_dout", dout0, 16'h0005);
        check("reset_men", {15'd0, men0}, 16'd0);
        check("reset_dout_h4", dout4, 16'h0005);
        repeat (2) clk_step();
        reset_n = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].op, vt[i].din, vt[i].wtbt, 1'b1, vt[i].dx, vt[i].dy, vt[i].btn,
                  vt[i].joy, vt[i].psel);
            check($sformatf("vec%0d_dout", i), dout0, vt[i].exp_dout);
            check($sformatf("vec%0d_men", i), {15'd0, men0}, {15'd0, vt[i].exp_men});
        end

        // randomized traffic; ce stays low so both instances must match the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int          sel, dx, dy;
            logic [1:0]  btn, wtbt;
            logic [15:0] joy, din;
            logic        psel, we;
            sel  = int'($urandom_range(0, 99));
            joy  = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(1, 16'hFFFF));
            psel = ($urandom_range(0, 4) != 0);
            btn  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) begin
                dx = int'($urandom_range(0, 511)) - 256;
                dy = int'($urandom_range(0, 511)) - 256;
            end else begin
                dx = int'($urandom_range(0, 16)) - 8;
                dy = int'($urandom_range(0, 16)) - 8;
            end
            din  = {12'($urandom), 1'($urandom_range(0, 3) != 0), 3'($urandom)};
            wtbt = ($urandom_range(0, 5) == 0) ? 2'b10 : 2'b01;
            we   = ($urandom_range(0, 9) != 0);
            if (sel < 60) begin
                drive(OP_PKT, din, wtbt, we, dx, dy, btn, joy, psel);
                model_packet(dx, dy, btn);
            end else if (sel < 80) begin
                drive(OP_WR, din, wtbt, we, dx, dy, btn, joy, psel);
                if (joy != 16'd0) m_src = 0;
                if (psel && we && wtbt[0]) model_write(din);
            end else begin
                drive(OP_IDLE, din, wtbt, we, dx, dy, btn, joy, psel);
                if (joy != 16'd0) m_src = 0;
            end
            check($sformatf("rnd%0d_dout", i), dout0, model_word(psel, joy));
            check($sformatf("rnd%0d_dout_h4", i), dout4, model_word(psel, joy));
            check($sformatf("rnd%0d_men", i), {15'd0, men0}, {15'd0, m_en});
        end

        // auto-release after exactly four ce ticks on the HOLD_TICKS=4 instance
        do_reset();
        drive(OP_WR, 16'h0008, 2'b01, 1'b1, 0, 0, 2'b00, 16'h0000, 1'b1);
        drive(OP_PKT, 16'h0000, 2'b00, 1'b1, 5, 0, 2'b00, 16'h0000, 1'b1);
        check("hold_set", dout4, 16'h0002);
        for (int t = 1; t <= 3; t++) begin
            ce_tick();
            check($sformatf("hold_ce%0d", t), dout4, 16'h0002);
        end
        ce_tick();
        check("hold_ce4_release", dout4, 16'h0000);
        check("hold0_kept", dout0, 16'h0002);

        // clear-write landing on the releasing ce tick
        drive(OP_PKT, 16'h0000, 2'b00, 1'b1, 5, 0, 2'b00, 16'h0000, 1'b1);
        check("coll_set", dout4, 16'h0002);
        repeat (3) ce_tick();
        check("coll_pre", dout4, 16'h0002);
        repeat (23) clk_step();
        bus_stb = 1'b1; bus_we = 1'b1; bus_wtbt = 2'b01; bus_din = 16'h0000;
        clk_step();
        bus_stb = 1'b0; bus_we = 1'b0; bus_wtbt = 2'b00;
        ce = 1'b1;
        clk_step();
        ce = 1'b0;
        check("coll_dout", dout4, 16'h0000);
        check("coll_men", {15'd0, men4}, 16'd0);

        // async reset in the middle of a hold
        drive(OP_WR, 16'h0008, 2'b01, 1'b1, 0, 0, 2'b00, 16'h0000, 1'b1);
        drive(OP_PKT, 16'h0000, 2'b00, 1'b1, 5, 0, 2'b00, 16'h0000, 1'b1);
        check("rst_hold_set", dout4, 16'h0002);
        ce_tick();
        #2;
        reset_n = 1'b0;
        joystick = 16'h00A5;
        ps2_mouse = 25'd0;
        tog = 1'b0;
        #1;
        check("rst_mid_dout", dout4, 16'h00A5);
        check("rst_mid_men", {15'd0, men4}, 16'd0);
        check("rst_mid_dout0", dout0, 16'h00A5);
        repeat (2) clk_step();
        reset_n = 1'b1;
        joystick = 16'h0000;
        clk_step();
        check("rst_after", dout4, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
